pixel_window_fetch: RTL and testbench

- Responder for the controller's `start_fetch` request.
- On each request it reads one source pixel, or a 2x2 source window, from the synchronous source image memory.
- It registers the pixels for the process stage and returns a one-cycle `fetch_done`.
- It sits between the image processor controller, the source frame RAM and the zoom/downscale datapath.

---
 rtl/pixel_window_fetch.sv | 170 +++++++++++++++++
 tb/tb_pixel_window_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_fetch.sv
// Pixel window fetch: on a start_fetch request, reads one pixel or a 2x2
// window from a 1-cycle synchronous source RAM. The pixels are registered on
// px0..px3 and a one-cycle fetch_done is returned. Out-of-range coordinates
// are rejected with fetch_err and no memory traffic.
module pixel_window_fetch #(
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_fetch,
   input  logic [1:0]        sw_mode,
   input  logic [7:0]        src_x,
   input  logic [7:0]        src_y,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic [PIX_W-1:0]  px0,
   output logic [PIX_W-1:0]  px1,
   output logic [PIX_W-1:0]  px2,
   output logic [PIX_W-1:0]  px3,
   output logic              fetch_done,
   output logic              fetch_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   // Coordinate limits widened by one bit so x+1 / y+1 cannot wrap
   localparam logic [8:0] W_LIM = 9'(IMG_W);
   localparam logic [8:0] H_LIM = 9'(IMG_H);

   state_t              state_reg, state_next;
   logic                mode2_reg, mode2_next;
   logic [7:0]          x_reg, x_next;
   logic [7:0]          y_reg, y_next;
   logic                err_reg, err_next;
   logic [1:0]          issue_cnt_reg, issue_cnt_next;
   logic [1:0]          cap_cnt_reg, cap_cnt_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                rd_en_reg, rd_en_next;
   logic                data_valid_reg;
   logic [1:0]          last_idx;
   logic [PIX_W-1:0]    px_reg [4];

   // Address of window element k (bit0 = right neighbour, bit1 = row below),
   // clamping at the right/bottom edges so edge pixels are replicated.
   function automatic logic [ADDR_W-1:0] win_addr(input logic [7:0] x,
                                                  input logic [7:0] y,
                                                  input logic [1:0] k);
      logic [7:0] xx;
      logic [7:0] yy;
      xx = x;
      yy = y;
      if (k[0] && (({1'b0, x} + 9'd1) < W_LIM)) xx = x + 8'd1;
      if (k[1] && (({1'b0, y} + 9'd1) < H_LIM)) yy = y + 8'd1;
      return ADDR_W'(yy) * ADDR_W'(IMG_W) + ADDR_W'(xx);
   endfunction

   assign last_idx = mode2_reg ? 2'd3 : 2'd0;

   // Next-state, read-issue and capture-index logic
   always_comb begin
      state_next     = state_reg;
      mode2_next     = mode2_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      err_next       = err_reg;
      issue_cnt_next = issue_cnt_reg;
      cap_cnt_next   = cap_cnt_reg;
      addr_next      = addr_reg;
      rd_en_next     = rd_en_reg;

      if (data_valid_reg) cap_cnt_next = cap_cnt_reg + 2'd1;

      case (state_reg)
         IDLE: begin
            if (start_fetch) begin
               mode2_next     = sw_mode[1];
               x_next         = src_x;
               y_next         = src_y;
               issue_cnt_next = 2'd0;
               cap_cnt_next   = 2'd0;
               if (({1'b0, src_x} >= W_LIM) || ({1'b0, src_y} >= H_LIM)) begin
                  // Rejected: one wait cycle in DRAIN keeps the done pulse
                  // on the same schedule as a one-cycle fetch pipeline.
                  err_next   = 1'b1;
                  state_next = DRAIN;
               end else begin
                  err_next   = 1'b0;
                  addr_next  = win_addr(src_x, src_y, 2'd0);
                  rd_en_next = 1'b1;
                  state_next = READ;
               end
            end
         end
         READ: begin
            if (issue_cnt_reg == last_idx) begin
               rd_en_next = 1'b0;
               state_next = DRAIN;
            end else begin
               issue_cnt_next = issue_cnt_reg + 2'd1;
               addr_next      = win_addr(x_reg, y_reg, issue_cnt_reg + 2'd1);
            end
         end
         DRAIN: begin
            if (err_reg) begin
               state_next = DONE;
            end else if (data_valid_reg && (cap_cnt_reg == last_idx)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         mode2_reg      <= 1'b0;
         x_reg          <= '0;
         y_reg          <= '0;
         err_reg        <= 1'b0;
         issue_cnt_reg  <= '0;
         cap_cnt_reg    <= '0;
         addr_reg       <= '0;
         rd_en_reg      <= 1'b0;
         data_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mode2_reg      <= mode2_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         err_reg        <= err_next;
         issue_cnt_reg  <= issue_cnt_next;
         cap_cnt_reg    <= cap_cnt_next;
         addr_reg       <= addr_next;
         rd_en_reg      <= rd_en_next;
         data_valid_reg <= rd_en_reg;
      end
   end

   // Pixel capture lanes: lane gi takes read gi; single mode fills all lanes
   for (genvar gi = 0; gi < 4; gi++) begin : g_px
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            px_reg[gi] <= '0;
         end else if (data_valid_reg && (!mode2_reg || (cap_cnt_reg == 2'(gi)))) begin
            px_reg[gi] <= mem_rd_data;
         end
      end
   end

   assign mem_addr   = addr_reg;
   assign mem_rd_en  = rd_en_reg;
   assign px0        = px_reg[0];
   assign px1        = px_reg[1];
   assign px2        = px_reg[2];
   assign px3        = px_reg[3];
   assign busy       = (state_reg != IDLE);
   assign fetch_done = (state_reg == DONE);
   assign fetch_err  = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Testbench for pixel_window_fetch: table of directed fetches plus
// hand-written sequences for mid-fetch requests and reset during READ.
module tb_pixel_window_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_fetch = 1'b0;
   logic [1:0]  sw_mode = 2'b00;
   logic [7:0]  src_x = 8'd0;
   logic [7:0]  src_y = 8'd0;
   logic [14:0] mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_data = 8'd0;
   logic [7:0]  px0, px1, px2, px3;
   logic        fetch_done, fetch_err, busy;

   int errors = 0;
   int checks = 0;
   logic [14:0] addr_q[$];

   pixel_window_fetch #(.IMG_W(160), .IMG_H(120), .PIX_W(8), .ADDR_W(15)) dut (
      .clk(clk), .reset_n(reset_n), .start_fetch(start_fetch), .sw_mode(sw_mode),
      .src_x(src_x), .src_y(src_y), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
      .mem_rd_data(mem_rd_data), .px0(px0), .px1(px1), .px2(px2), .px3(px3),
      .fetch_done(fetch_done), .fetch_err(fetch_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Source RAM model: content = addr[7:0], 1-cycle synchronous read
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem_addr[7:0];
         addr_q.push_back(mem_addr);
      end
   end

   typedef struct packed {
      logic [1:0]  mode;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [2:0]  n;
      logic [14:0] a0, a1, a2, a3;
      logic [7:0]  p0, p1, p2, p3;
      logic        err;
      logic [3:0]  lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [1:0] mode, logic [7:0] x, logic [7:0] y,
                               logic [2:0] n, logic [14:0] a0, logic [14:0] a1,
                               logic [14:0] a2, logic [14:0] a3, logic [7:0] p0,
                               logic [7:0] p1, logic [7:0] p2, logic [7:0] p3,
                               logic err, logic [3:0] lat);
      vec_t v;
      v.mode = mode; v.x = x; v.y = y; v.n = n;
      v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
      v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
      v.err = err; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_addr"}, int'(mem_addr), 0);
      chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
      chk({tag, "_px"}, int'({px0, px1, px2, px3}), 0);
      chk({tag, "_done"}, int'(fetch_done), 0);
      chk({tag, "_err"}, int'(fetch_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   // Issue one request (sampled at the next edge E0) and wait for fetch_done.
   // lat counts edges from E0 (=1) to the edge after which fetch_done is seen.
   task automatic run_fetch(input logic [1:0] mode, input logic [7:0] x,
                            input logic [7:0] y, output int lat,
                            output int err, output int busy_cnt);
      bit done;
      sw_mode = mode; src_x = x; src_y = y; start_fetch = 1'b1;
      @(posedge clk); #1;
      start_fetch = 1'b0;
      sw_mode = ~mode; src_x = 8'($urandom); src_y = 8'($urandom);
      lat = 1; err = 0; busy_cnt = 0; done = 1'b0;
      while (!done && lat < 30) begin
         if (busy) busy_cnt++;
         if (fetch_done) begin
            done = 1'b1;
            err = int'(fetch_err);
         end else begin
            @(posedge clk); #1;
            lat++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, err, bcnt, dones;
      logic [14:0] ea[4];
      logic [7:0]  ep[4];
      logic [7:0]  ap[4];

      vecs.push_back(mk(2'b10, 8'd10,  8'd5,   3'd4, 15'd810, 15'd811, 15'd970, 15'd971, 8'h2A, 8'h2B, 8'hCA, 8'hCB, 1'b0, 4'd6));
      vecs.push_back(mk(2'b00, 8'd3,   8'd0,   3'd1, 15'd3, 15'd0, 15'd0, 15'd0, 8'h03, 8'h03, 8'h03, 8'h03, 1'b0, 4'd3));
      vecs.push_back(mk(2'b10, 8'd159, 8'd119, 3'd4, 15'd19199, 15'd19199, 15'd19199, 15'd19199, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 4'd6));
      vecs.push_back(mk(2'b10, 8'd160, 8'd0,   3'd0, 15'd0, 15'd0, 15'd0, 15'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd2));
      vecs.push_back(mk(2'b11, 8'd159, 8'd0,   3'd4, 15'd159, 15'd159, 15'd319, 15'd319, 8'h9F, 8'h9F, 8'h3F, 8'h3F, 1'b0, 4'd6));
      vecs.push_back(mk(2'b01, 8'd0,   8'd119, 3'd1, 15'd19040, 15'd0, 15'd0, 15'd0, 8'h60, 8'h60, 8'h60, 8'h60, 1'b0, 4'd3));
      vecs.push_back(mk(2'b00, 8'd0,   8'd120, 3'd0, 15'd0, 15'd0, 15'd0, 15'd0, 8'h60, 8'h60, 8'h60, 8'h60, 1'b1, 4'd2));
      vecs.push_back(mk(2'b10, 8'd0,   8'd0,   3'd4, 15'd0, 15'd1, 15'd160, 15'd161, 8'h00, 8'h01, 8'hA0, 8'hA1, 1'b0, 4'd6));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven fetches, each launched in the first IDLE cycle after the previous done
      foreach (vecs[i]) begin
         addr_q.delete();
         run_fetch(vecs[i].mode, vecs[i].x, vecs[i].y, lat, err, bcnt);
         chk($sformatf("v%0d_latency", i), lat, int'(vecs[i].lat));
         chk($sformatf("v%0d_err", i), err, int'(vecs[i].err));
         chk($sformatf("v%0d_busy_cycles", i), bcnt, int'(vecs[i].lat));
         chk($sformatf("v%0d_nreads", i), addr_q.size(), int'(vecs[i].n));
         ea = '{vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3};
         ep = '{vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3};
         ap = '{px0, px1, px2, px3};
         for (int j = 0; j < int'(vecs[i].n) && j < addr_q.size(); j++)
            chk($sformatf("v%0d_addr%0d", i, j), int'(addr_q[j]), int'(ea[j]));
         for (int j = 0; j < 4; j++)
            chk($sformatf("v%0d_px%0d", i, j), int'(ap[j]), int'(ep[j]));
         $display("vec %0d mode=%b x=%0d y=%0d lat=%0d err=%0d reads=%0d px=%h %h %h %h",
                  i, vecs[i].mode, vecs[i].x, vecs[i].y, lat, err, addr_q.size(),
                  px0, px1, px2, px3);
         @(posedge clk); #1;
      end

      // Second request while busy must be ignored
      addr_q.delete();
      sw_mode = 2'b10; src_x = 8'd10; src_y = 8'd5; start_fetch = 1'b1;
      @(posedge clk); #1;
      start_fetch = 1'b0;
      @(posedge clk); #1;
      sw_mode = 2'b00; src_x = 8'd3; src_y = 8'd0; start_fetch = 1'b1;
      @(posedge clk); #1;
      start_fetch = 1'b0;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         if (fetch_done) dones++;
         @(posedge clk); #1;
      end
      chk("busy_ignore_dones", dones, 1);
      chk("busy_ignore_nreads", addr_q.size(), 4);
      if (addr_q.size() == 4) chk("busy_ignore_addr3", int'(addr_q[3]), 971);
      chk("busy_ignore_px", int'({px0, px1, px2, px3}), int'(32'h2A2BCACB));
      $display("busy-ignore sequence dones=%0d reads=%0d px=%h %h %h %h",
               dones, addr_q.size(), px0, px1, px2, px3);

      // Reset asserted during READ of a 2x2 fetch
      sw_mode = 2'b10; src_x = 8'd20; src_y = 8'd7; start_fetch = 1'b1;
      @(posedge clk); #1;
      start_fetch = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (fetch_done) dones++;
      end
      chk("midreset_no_done", dones, 0);
      addr_q.delete();
      run_fetch(2'b10, 8'd10, 8'd5, lat, err, bcnt);
      chk("after_reset_latency", lat, 6);
      chk("after_reset_nreads", addr_q.size(), 4);
      chk("after_reset_px", int'({px0, px1, px2, px3}), int'(32'h2A2BCACB));
      $display("reset-recovery fetch lat=%0d reads=%0d px=%h %h %h %h",
               lat, addr_q.size(), px0, px1, px2, px3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
